// File: rtl/smi_pkg.sv
// Shared constants, field widths and FSM state type for the SMI/MDIO responder.
package smi_pkg;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam int unsigned PHYAD_W = 5;
    localparam int unsigned REGAD_W = 5;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned TA_W    = 2;

    typedef enum logic [3:0] {
        StIdle,
        StSt,
        StOp,
        StPhyad,
        StRegad,
        StTa,
        StRdata,
        StWdata,
        StSkip
    } smi_resp_state_t;

    // Bit-counter value on the last bit of an n-bit field (counter starts at 0).
    function automatic logic [4:0] last_idx(input int unsigned n);
        return 5'(n - 1);
    endfunction

endpackage

// File: rtl/smi_mdc_sync.sv
// Two-flop synchronizers for MDC and MDIO plus rising/falling edge pulses of synced MDC.
// The synced MDIO has the same latency as the edge pulses, so it is the bit value
// present on the line at the corresponding MDC edge.
module smi_mdc_sync (
    input  logic clk,
    input  logic i_reset,
    input  logic i_mdc,
    input  logic i_mdio,
    output logic o_mdio,
    output logic o_mdc_rise,
    output logic o_mdc_fall
);

    logic r_mdc_meta;
    logic r_mdc_sync;
    logic r_mdc_prev;
    logic r_mdio_meta;
    logic r_mdio_sync;

    // Synchronize both lines and keep one delayed copy of MDC for edge detection.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_mdc_meta  <= 1'b0;
            r_mdc_sync  <= 1'b0;
            r_mdc_prev  <= 1'b0;
            r_mdio_meta <= 1'b1;
            r_mdio_sync <= 1'b1;
        end else begin
            r_mdc_meta  <= i_mdc;
            r_mdc_sync  <= r_mdc_meta;
            r_mdc_prev  <= r_mdc_sync;
            r_mdio_meta <= i_mdio;
            r_mdio_sync <= r_mdio_meta;
        end
    end

    assign o_mdio     = r_mdio_sync;
    assign o_mdc_rise = r_mdc_sync & ~r_mdc_prev;
    assign o_mdc_fall = ~r_mdc_sync & r_mdc_prev;

endmodule

// File: rtl/smi_mdio_responder.sv
// Clause 22 SMI/MDIO target: decodes frames on MDC/MDIO and serves a register-file port.
// Build option: define SMI_PREAMBLE_CHECK_EN to require PREAMBLE_LEN consecutive 1s
// before a start code is accepted; by default a single sampled 1 arms start detection.
module smi_mdio_responder
    import smi_pkg::*;
#(
    parameter logic [PHYAD_W-1:0] PHY_ADDR     = 5'd0,
    parameter int unsigned        PREAMBLE_LEN = 32
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_mdc,
    inout  wire                io_mdio,
    output logic [REGAD_W-1:0] o_reg_addr,
    output logic               o_rd_req,
    input  logic [DATA_W-1:0]  i_rd_data,
    output logic               o_wr_en,
    output logic [DATA_W-1:0]  o_wr_data,
    output logic               o_err
);

    localparam logic [4:0] PHY_LAST      = last_idx(PHYAD_W);
    localparam logic [4:0] REG_LAST      = last_idx(REGAD_W);
    localparam logic [4:0] DATA_LAST     = last_idx(DATA_W);
    localparam logic [4:0] RD_DONE       = 5'(DATA_W);
    // Remaining rising edges to swallow, expressed as the last counter value.
    localparam logic [4:0] SKIP_ADDR     = last_idx(TA_W + DATA_W);
    localparam logic [4:0] SKIP_TA_BIT1  = last_idx(TA_W - 1 + DATA_W);
    localparam logic [4:0] SKIP_TA_BIT2  = last_idx(DATA_W);

    logic w_mdio;
    logic w_rise;
    logic w_fall;

    smi_resp_state_t    r_state;
    logic [4:0]         r_bit_cnt;
    logic [4:0]         r_skip_last;
    logic               r_op_hi;
    logic               r_is_read;
    logic [PHYAD_W-1:0] r_phy;
    logic               r_phy_match;
    logic [REGAD_W-1:0] r_reg_addr;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  r_wr_data;
    logic               r_rd_req;
    logic               r_rd_lat;
    logic               r_wr_en;
    logic               r_err;
    logic               r_mdio_oe;
    logic               r_mdio_out;
`ifdef SMI_PREAMBLE_CHECK_EN
    logic [5:0]         r_pre_cnt;
`else
    logic               r_armed;
    logic               w_unused_preamble;
    assign w_unused_preamble = ^PREAMBLE_LEN;
`endif

    smi_mdc_sync u_sync (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_mdc      (i_mdc),
        .i_mdio     (io_mdio),
        .o_mdio     (w_mdio),
        .o_mdc_rise (w_rise),
        .o_mdc_fall (w_fall)
    );

    // Line is released asynchronously by reset because r_mdio_oe is async-cleared.
    assign io_mdio = r_mdio_oe ? r_mdio_out : 1'bz;

    assign o_reg_addr = r_reg_addr;
    assign o_rd_req   = r_rd_req;
    assign o_wr_en    = r_wr_en;
    assign o_wr_data  = r_wr_data;
    assign o_err      = r_err;

    // Frame decoder FSM: samples on synced MDC rise, changes drive on synced MDC fall.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_bit_cnt   <= 5'd0;
            r_skip_last <= 5'd0;
            r_op_hi     <= 1'b0;
            r_is_read   <= 1'b0;
            r_phy       <= '0;
            r_phy_match <= 1'b0;
            r_reg_addr  <= '0;
            r_shift     <= '0;
            r_wr_data   <= '0;
            r_rd_req    <= 1'b0;
            r_rd_lat    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_err       <= 1'b0;
            r_mdio_oe   <= 1'b0;
            r_mdio_out  <= 1'b0;
`ifdef SMI_PREAMBLE_CHECK_EN
            r_pre_cnt   <= 6'd0;
`else
            r_armed     <= 1'b0;
`endif
        end else begin
            r_rd_req <= 1'b0;
            r_wr_en  <= 1'b0;
            r_err    <= 1'b0;
            // Register file answers one clock after the strobe.
            r_rd_lat <= r_rd_req;
            if (r_rd_lat) begin
                r_shift <= i_rd_data;
            end

            case (r_state)
                StIdle: begin
                    if (w_rise) begin
`ifdef SMI_PREAMBLE_CHECK_EN
                        if (w_mdio) begin
                            if (r_pre_cnt != 6'd63) begin
                                r_pre_cnt <= r_pre_cnt + 6'd1;
                            end
                        end else if ({26'd0, r_pre_cnt} >= PREAMBLE_LEN) begin
                            r_pre_cnt <= 6'd0;
                            r_bit_cnt <= 5'd0;
                            r_state   <= StSt;
                        end else begin
                            r_pre_cnt <= 6'd0;
                        end
`else
                        if (w_mdio) begin
                            r_armed <= 1'b1;
                        end else if (r_armed) begin
                            r_armed   <= 1'b0;
                            r_bit_cnt <= 5'd0;
                            r_state   <= StSt;
                        end
`endif
                    end
                end

                StSt: begin
                    if (w_rise) begin
                        r_bit_cnt <= 5'd0;
                        if (w_mdio == ST_CODE[0]) begin
                            r_state <= StOp;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= StIdle;
                        end
                    end
                end

                StOp: begin
                    if (w_rise) begin
                        if (r_bit_cnt == 5'd0) begin
                            r_op_hi   <= w_mdio;
                            r_bit_cnt <= 5'd1;
                        end else begin
                            r_bit_cnt <= 5'd0;
                            if ({r_op_hi, w_mdio} == OP_READ) begin
                                r_is_read <= 1'b1;
                                r_state   <= StPhyad;
                            end else if ({r_op_hi, w_mdio} == OP_WRITE) begin
                                r_is_read <= 1'b0;
                                r_state   <= StPhyad;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= StIdle;
                            end
                        end
                    end
                end

                StPhyad: begin
                    if (w_rise) begin
                        r_phy <= {r_phy[PHYAD_W-2:0], w_mdio};
                        if (r_bit_cnt == PHY_LAST) begin
                            r_phy_match <= ({r_phy[PHYAD_W-2:0], w_mdio} == PHY_ADDR);
                            r_bit_cnt   <= 5'd0;
                            r_state     <= StRegad;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end

                StRegad: begin
                    if (w_rise) begin
                        r_reg_addr <= {r_reg_addr[REGAD_W-2:0], w_mdio};
                        if (r_bit_cnt == REG_LAST) begin
                            r_bit_cnt <= 5'd0;
                            if (!r_phy_match) begin
                                r_skip_last <= SKIP_ADDR;
                                r_state     <= StSkip;
                            end else begin
                                r_rd_req <= r_is_read;
                                r_state  <= StTa;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end

                StTa: begin
                    if (r_is_read) begin
                        // Bit 1 stays released; start driving 0 at the fall that ends it.
                        if (w_rise && r_bit_cnt == 5'd0) begin
                            r_bit_cnt <= 5'd1;
                        end else if (w_fall && r_bit_cnt == 5'd1) begin
                            r_mdio_oe  <= 1'b1;
                            r_mdio_out <= 1'b0;
                            r_bit_cnt  <= 5'd0;
                            r_state    <= StRdata;
                        end
                    end else if (w_rise) begin
                        if (r_bit_cnt == 5'd0) begin
                            if (!w_mdio) begin
                                r_err       <= 1'b1;
                                r_skip_last <= SKIP_TA_BIT1;
                                r_state     <= StSkip;
                            end else begin
                                r_bit_cnt <= 5'd1;
                            end
                        end else begin
                            r_bit_cnt <= 5'd0;
                            if (w_mdio) begin
                                r_err       <= 1'b1;
                                r_skip_last <= SKIP_TA_BIT2;
                                r_state     <= StSkip;
                            end else begin
                                r_state <= StWdata;
                            end
                        end
                    end
                end

                StRdata: begin
                    if (w_fall) begin
                        if (r_bit_cnt == RD_DONE) begin
                            r_mdio_oe <= 1'b0;
                            r_bit_cnt <= 5'd0;
                            r_state   <= StIdle;
                        end else begin
                            r_mdio_out <= r_shift[DATA_W-1];
                            r_shift    <= {r_shift[DATA_W-2:0], 1'b0};
                            r_bit_cnt  <= r_bit_cnt + 5'd1;
                        end
                    end
                end

                StWdata: begin
                    if (w_rise) begin
                        r_shift <= {r_shift[DATA_W-2:0], w_mdio};
                        if (r_bit_cnt == DATA_LAST) begin
                            r_wr_data <= {r_shift[DATA_W-2:0], w_mdio};
                            r_wr_en   <= 1'b1;
                            r_bit_cnt <= 5'd0;
                            r_state   <= StIdle;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end

                StSkip: begin
                    if (w_rise) begin
                        if (r_bit_cnt == r_skip_last) begin
                            r_bit_cnt <= 5'd0;
                            r_state   <= StIdle;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end

                default: begin
                    r_bit_cnt <= 5'd0;
                    r_mdio_oe <= 1'b0;
                    r_state   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smi_mdio_responder.sv
// Directed bench for smi_mdio_responder acting as the MDIO initiator with a pulled-up line.
module tb_smi_mdio_responder;

    localparam logic [4:0] PHY = 5'd3;
`ifdef SMI_PREAMBLE_CHECK_EN
    localparam int PRE = 32;
`else
    localparam int PRE = 2;
`endif

    typedef struct packed {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mdc;
    logic        tb_oe;
    logic        tb_out;
    wire         mdio;
    logic [4:0]  reg_addr;
    logic        rd_req;
    logic [15:0] rd_data;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        err;

    logic [15:0] mem [32];
    wr_t         exp_wr_q[$];
    logic [4:0]  exp_rd_q[$];
    wr_t         mon_w;
    logic [4:0]  mon_a;

    int n_assert = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int err_exp  = 0;
    int wr_seen  = 0;
    int rd_seen  = 0;

    pullup pu_mdio (mdio);
    assign mdio = tb_oe ? tb_out : 1'bz;

    smi_mdio_responder #(
        .PHY_ADDR     (PHY),
        .PREAMBLE_LEN (32)
    ) dut (
        .clk        (clk),
        .i_reset    (rst),
        .i_mdc      (mdc),
        .io_mdio    (mdio),
        .o_reg_addr (reg_addr),
        .o_rd_req   (rd_req),
        .i_rd_data  (rd_data),
        .o_wr_en    (wr_en),
        .o_wr_data  (wr_data),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    // Register file: read data appears one clock after the strobe.
    always @(posedge clk) begin
        if (rd_req) rd_data <= mem[reg_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop expected strobes as the DUT produces them.
    always @(negedge clk) begin
        if (err) err_seen++;
        if (wr_en) begin
            wr_seen++;
            if (exp_wr_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL wr_unexpected: observed addr %0h data %0h expected no write",
                       reg_addr, wr_data);
            end else begin
                mon_w = exp_wr_q.pop_front();
                check("wr_addr", 32'(reg_addr), 32'(mon_w.a));
                check("wr_data", 32'(wr_data), 32'(mon_w.d));
            end
        end
        if (rd_req) begin
            rd_seen++;
            if (exp_rd_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL rd_unexpected: observed addr %0h expected no read", reg_addr);
            end else begin
                mon_a = exp_rd_q.pop_front();
                check("rd_addr", 32'(reg_addr), 32'(mon_a));
            end
        end
    end

    // One MDC period: drive set after the falling edge, sample at the rising edge.
    task automatic mdc_cycle(input logic oe, input logic val, output logic smp);
        tb_oe  = oe;
        tb_out = val;
        #80;
        mdc = 1'b1;
        smp = mdio;
        #80;
        mdc = 1'b0;
    endtask

    task automatic drive_bits(input logic [31:0] v, input int n);
        logic s;
        for (int i = n - 1; i >= 0; i--) mdc_cycle(1'b1, v[i], s);
        tb_oe = 1'b0;
    endtask

    task automatic release_bits(input int n, output logic [17:0] v);
        logic s;
        v = '0;
        tb_oe = 1'b0;
        for (int i = 0; i < n; i++) begin
            mdc_cycle(1'b0, 1'b0, s);
            v = {v[16:0], s};
        end
    endtask

    task automatic send_header(input int pre_n, input logic [1:0] op, input logic [4:0] phy,
                               input logic [4:0] ra);
        logic [17:0] dummy;
        release_bits(pre_n, dummy);
        drive_bits({18'd0, 2'b01, op, phy, ra}, 14);
    endtask

    task automatic idle_check(input string tag);
        logic [17:0] v;
        release_bits(1, v);
        check(tag, 32'(v[0]), 32'd1);
    endtask

    initial begin : stim
        logic [17:0] v;
        for (int i = 0; i < 32; i++) mem[i] = 16'(i * 16'h0101);
        mem[5'h02] = 16'h0007;
        mem[5'h1E] = 16'hB38D;
        rd_data = '0;
        mdc     = 1'b0;
        tb_oe   = 1'b0;
        tb_out  = 1'b0;
        rst     = 1'b1;
        #40;
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mdio_released", 32'(mdio), 32'd1);
        #20 rst = 1'b0;
        #40;

        // Write PHY 3, reg 9
        exp_wr_q.push_back('{a: 5'h09, d: 16'hA5C3});
        send_header(PRE, 2'b01, PHY, 5'h09);
        drive_bits({14'd0, 2'b10, 16'hA5C3}, 18);
        idle_check("wr1_released");
        check("wr1_pending", 32'(exp_wr_q.size()), 32'd0);
        check("wr1_count", 32'(wr_seen), 32'd1);

        // Read PHY 3, reg 2: TA released then 0, then data
        exp_rd_q.push_back(5'h02);
        send_header(PRE, 2'b10, PHY, 5'h02);
        release_bits(18, v);
        check("rd1_ta_data", 32'(v), 32'({2'b10, 16'h0007}));
        idle_check("rd1_released");
        check("rd1_pending", 32'(exp_rd_q.size()), 32'd0);

        // Read to another PHY: passive, then back-to-back frame to PHY 3
        send_header(PRE, 2'b10, 5'd5, 5'h02);
        release_bits(18, v);
        check("other_phy_line", 32'(v), 32'h3FFFF);
        exp_rd_q.push_back(5'h1E);
        send_header(PRE - 1, 2'b10, PHY, 5'h1E);
        release_bits(18, v);
        check("rd2_ta_data", 32'(v), 32'({2'b10, 16'hB38D}));
        check("rd2_count", 32'(rd_seen), 32'd2);

        // Opcode 11
        err_exp++;
        release_bits(PRE, v);
        drive_bits({28'd0, 2'b01, 2'b11}, 4);
        idle_check("op11_released");
        check("op11_err", 32'(err_seen), 32'(err_exp));

        // Write with TA 00
        err_exp++;
        send_header(PRE, 2'b01, PHY, 5'h04);
        drive_bits({14'd0, 2'b00, 16'h1234}, 18);
        idle_check("ta00_released");
        check("ta00_err", 32'(err_seen), 32'(err_exp));
        check("ta00_no_write", 32'(wr_seen), 32'd1);

        // Reset while driving read data
        exp_rd_q.push_back(5'h02);
        send_header(PRE, 2'b10, PHY, 5'h02);
        release_bits(5, v);
        check("rst_mid_ta", 32'(v[4:0]), 32'b10000);
        #60;
        check("rst_mid_driving", 32'(mdio), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_released", 32'(mdio), 32'd1);
        #39;
        rst = 1'b0;
        #20;
        exp_wr_q.push_back('{a: 5'h11, d: 16'h5A0F});
        send_header(PRE, 2'b01, PHY, 5'h11);
        drive_bits({14'd0, 2'b10, 16'h5A0F}, 18);
        idle_check("wr2_released");
        check("wr2_pending", 32'(exp_wr_q.size()), 32'd0);

`ifdef SMI_PREAMBLE_CHECK_EN
        // A 0 clears the run of ones left by the previous idle bit.
        drive_bits(32'd0, 1);
        send_header(31, 2'b01, PHY, 5'h07);
        drive_bits({14'd0, 2'b10, 16'h0F0F}, 18);
        check("pre31_ignored", 32'(wr_seen), 32'd2);
        exp_wr_q.push_back('{a: 5'h07, d: 16'h0F0F});
        send_header(32, 2'b01, PHY, 5'h07);
        drive_bits({14'd0, 2'b10, 16'h0F0F}, 18);
        idle_check("pre32_released");
        check("pre32_accepted", 32'(wr_seen), 32'd3);
`endif

        check("total_err", 32'(err_seen), 32'(err_exp));
        check("total_rd", 32'(rd_seen), 32'd3);
        check("rd_pending_end", 32'(exp_rd_q.size()), 32'd0);
        check("wr_pending_end", 32'(exp_wr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/smi_mdio_responder.md
# smi_mdio_responder

PHY-side (target) end of the IEEE 802.3 clause 22 SMI/MDIO management bus. Watches MDC and MDIO driven by the station-management initiator, decodes start, opcode, PHY and register addresses, and serves 16-bit register reads and writes through a simple single-cycle register-file port. Used as the PHY model in system benches and as the management front end of FPGA-side PHY/MMD emulation blocks.

## Interface
- PHY_ADDR, 5'd0: PHY address this responder answers to; all other addresses are ignored passively.
- PREAMBLE_LEN, 32: minimum consecutive 1s before ST (only with SMI_PREAMBLE_CHECK_EN).
- clk  input  1  system clock; must be ≥8× MDC frequency.
- i_reset  input  1  asynchronous, active-high reset.
- i_mdc  input  1  MDC from initiator, asynchronous to clk.
- io_mdio  inout  1  MDIO line; driven only during read TA bit 2 and read data, else 'z.
- o_reg_addr  output  5  register address of current access.
- o_rd_req  output  1  one-cycle read strobe.
- i_rd_data  input  16  read data; sampled exactly 1 clk after o_rd_req.
- o_wr_en  output  1  one-cycle write strobe.
- o_wr_data  output  16  write data, valid with o_wr_en.
- o_err  output  1  one-cycle pulse on malformed frame.

## Operation
- i_mdc and io_mdio pass through 2-flop synchronizers; edge detect on synced MDC. Bits sampled on MDC rising; drive changes on MDC falling.
- States: IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA, SKIP. 5-bit bit counter, reset to 0 on every state entry.
- IDLE: MDIO sampled 1 arms start detection; sampled 0 after arming → ST (that 0 is ST bit 1).
- ST: second bit must be 1, else o_err, → IDLE.
- OP: 2 bits; 10 = read, 01 = write; 00/11 → o_err, → IDLE.
- PHYAD: 5 bits MSB first. REGAD: 5 bits MSB first, shifted into o_reg_addr.
- On last REGAD sample: mismatch → SKIP; match and read → o_rd_req pulse; i_rd_data latched next clk into shift register; → TA.
- TA read: bit 1 line released; at falling edge ending bit 1, drive 0; → RDATA.
- TA write: expect sampled 1 then 0; mismatch → o_err, → SKIP (no write).
- RDATA: at each falling edge shift out next bit MSB first (16 bits); falling edge after 16th rising edge releases line, → IDLE.
- WDATA: sample 16 bits MSB first; after 16th sample, o_wr_en pulses 1 clk with o_wr_data; → IDLE.
- SKIP: never drives; counts 18 rising edges (TA + data), → IDLE.
- Back-to-back frames without preamble accepted (line idle-high between frames re-arms IDLE).
- Reset mid-frame: line released immediately (async), all state cleared.

## Timing
- Reset values: o_reg_addr 0, o_wr_data 0, o_rd_req 0, o_wr_en 0, o_err 0, io_mdio 'z.
- MDIO drive changes 3–4 clk after MDC falling edge (2 sync + edge + output reg); requires MDC half-period ≥4 clk so data is stable before next rising edge.
- o_rd_req asserted 3–4 clk after last REGAD rising edge; i_rd_data captured next clk, well before TA bit 2 drive.
- o_wr_en asserted 3–4 clk after 16th data rising edge.
- o_err asserted in clk following the offending sample.

## Configuration
- SMI_PREAMBLE_CHECK_EN defined: IDLE requires ≥PREAMBLE_LEN consecutive sampled 1s (6-bit saturating counter) before ST accepted; a 0 earlier resets count, no o_err.
- Undefined (default): preamble suppression; a single sampled 1 arms start detection. Required for initiators that send a short reset preamble only.

## Structure
- Package smi_pkg: ST_CODE 2'b01, OP_READ 2'b10, OP_WRITE 2'b01, field widths (PHYAD/REGAD 5, DATA 16, TA 2), state enum smi_resp_state_t.
- Sub-module smi_mdc_sync: 2-flop sync of MDC and MDIO plus rising/falling edge pulses.

## Test plan
- PHY_ADDR=5'd3; write frame PHY 3, REG 5'h09, data 16'hA5C3 → one o_wr_en with o_reg_addr=9, o_wr_data=16'hA5C3; io_mdio never driven.
- Read frame PHY 3, REG 5'h02, i_rd_data=16'h0007 → one o_rd_req with o_reg_addr=2; initiator samples TA 0 then 16'h0007.
- Read frame to PHY 5 → no strobes, io_mdio 'z throughout; following frame to PHY 3 served normally.
- Opcode 11 → o_err pulse, no strobes; write with TA 00 → o_err, no o_wr_en.
- i_reset asserted mid RDATA → io_mdio 'z same cycle; next frame decoded correctly.
- With SMI_PREAMBLE_CHECK_EN, PREAMBLE_LEN=32: 31 ones then valid write → ignored; 32 ones → write accepted.
